// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic/shift ops plus an iterative
// 32-cycle shift-add multiplier, with a valid/ready handshake on both sides.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               alu_control,
    input  logic [WIDTH-1:0]         src_a,
    input  logic [WIDTH-1:0]         src_b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd15;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] op_result;
    logic             accept, consume, is_mul, mul_done;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign is_mul   = (alu_control == OP_MUL);
    assign mul_done = (state == MUL) && (cnt == CW'(WIDTH - 1));
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign zero     = (result == '0);

    always_comb begin
        op_result = '0;
        unique case (alu_control)
            4'd0:    op_result = src_a & src_b;
            4'd1:    op_result = src_a | src_b;
            4'd2:    op_result = src_a + src_b;
            4'd6:    op_result = src_a - src_b;
            4'd7:    op_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd12:   op_result = src_a ^ src_b;
            4'd13:   op_result = src_b << shamt;
            4'd14:   op_result = src_b >> shamt;
            default: op_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept && is_mul) state_next = MUL;
                MUL:  if (mul_done) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Flushed operations are dropped but the last result register is left intact.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_done) begin
                result    <= acc_next;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end else if (accept && is_mul) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
            if (consume) out_valid <= 1'b0;
        end else if (accept) begin
            result    <= op_result;
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: table of single-cycle vectors plus directed
// multiply, backpressure, flush and mid-multiply reset sequences.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    alu_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .src_a      (src_a),
        .src_b      (src_b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        shamt       = sh;
    endtask

    task automatic runMul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        out_ready = 1'b1;
        applyStimulus(4'd15, a, b, 5'd0);
        checkOutput("mul_in_ready_before", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin
            n++;
            tick();
        end
        checkOutput("mul_busy_cycles", n, 32'd32);
        checkOutput("mul_out_valid", 32'(out_valid), 32'd1);
        checkOutput("mul_result", result, exp);
        checkOutput("mul_zero", 32'(zero), 32'(exp == 32'd0));
        tick();
    endtask

    initial begin
        int seen;
        vecs = '{
            '{4'd2,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000},
            '{4'd6,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000},
            '{4'd7,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001},
            '{4'd7,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000},
            '{4'd13, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000},
            '{4'd13, 32'h00000000, 32'h00001234, 5'd0,  32'h00001234},
            '{4'd14, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001},
            '{4'd14, 32'h00000000, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF},
            '{4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000},
            '{4'd0,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000},
            '{4'd1,  32'h0000F0F0, 32'h00000F0F, 5'd0,  32'h0000FFFF},
            '{4'd12, 32'h000000FF, 32'h0000000F, 5'd0,  32'h000000F0},
            '{4'd8,  32'h12345678, 32'h11111111, 5'd0,  32'h00000000},
            '{4'd11, 32'h12345678, 32'h11111111, 5'd0,  32'h00000000}
        };

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = 4'd0; src_a = '0; src_b = '0; shamt = '0;
        #22;
        resetn = 1'b1;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd1);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Back-to-back single-cycle ops, one result per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d_result", i), result, vecs[i].exp);
            checkOutput($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp == 32'd0));
        end
        in_valid = 1'b0;
        tick();
        checkOutput("idle_out_valid_clears", 32'(out_valid), 32'd0);

        runMul(32'h00010003, 32'h00020005, 32'h000B000F);
        runMul(32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB);

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        applyStimulus(4'd0, 32'h000000F0, 32'h0000003C, 5'd0);
        tick();
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_result", result, 32'h00000030);
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        applyStimulus(4'd1, 32'h00000001, 32'h00000002, 5'd0);
        tick();
        checkOutput("bp_result_stable", result, 32'h00000030);
        checkOutput("bp_out_valid_stable", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        checkOutput("bp_next_result", result, 32'h00000003);
        checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        checkOutput("bp_no_duplicate", 32'(out_valid), 32'd0);

        // Flush at MUL cycle 10.
        applyStimulus(4'd15, 32'h00000003, 32'h00000005, 5'd0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_result_kept", result, 32'h00000003);
        seen = 0;
        repeat (30) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("flush_no_late_result", seen, 32'd0);
        applyStimulus(4'd1, 32'h00000005, 32'h00000002, 5'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("post_flush_valid", 32'(out_valid), 32'd1);
        checkOutput("post_flush_result", result, 32'h00000007);
        tick();

        // Reset pulse mid-multiply.
        applyStimulus(4'd15, 32'h00000009, 32'h00000009, 5'd0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_result", result, 32'd0);
        checkOutput("rst_mid_zero", 32'(zero), 32'd1);
        #3;
        resetn = 1'b1;
        #1;
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("rst_no_result", seen, 32'd0);
        checkOutput("rst_result_still_zero", result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage arithmetic unit that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with the two register/immediate operands and the shift amount. It returns a registered 32-bit result and a zero flag through a valid/ready handshake. Codes 0, 1, 2, 6, 7, 12, 13 and 14 complete in one cycle. Code 15 (multiply) runs an iterative 32-cycle shift-add multiplier and holds off new operations until it finishes. It sits between ID/EX operand selection and the EX/MEM register, and drives the pipeline stall through `in_ready`.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported; the counter and shift widths are derived from it.
- `clk` input 1: rising-edge clock.
- `resetn` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: an operation is presented.
- `in_ready` output 1: the unit accepts an operation this cycle.
- `alu_control` input 4: operation code.
- `src_a` input 32: operand A.
- `src_b` input 32: operand B. This is also the shifted operand.
- `shamt` input 5: shift amount.
- `out_valid` output 1: `result` holds a completed operation.
- `out_ready` input 1: the consumer takes the result.
- `result` output 32: registered result.
- `zero` output 1: `(result == 0)`, combinational from the result register.

## Operation
Operation codes:
- 0: `a & b`
- 1: `a | b`
- 2: `a + b`, wrapping, no overflow trap
- 6: `a - b`, wrapping
- 7: `a < b` signed, giving 1 or 0
- 12: `a ^ b`
- 13: `b << shamt`
- 14: `b >> shamt`, logical
- 15: low 32 bits of `a * b`. The low word is identical for signed and unsigned.
- 3, 4, 5, 8–11: result 0. Code 3 is the decoder's "no-op/undefined" code.

State machine, two states:
- IDLE → IDLE: a non-multiply operation is accepted.
- IDLE → MUL: code 15 is accepted. On that edge: `mcand <= src_a`, `mplier <= src_b`, `acc <= 0`, `cnt <= 0`.
- Each MUL edge:
  - If `mplier[0]` is 1, `acc += mcand`.
  - Then `mcand <<= 1`, `mplier >>= 1`, `cnt += 1`.
  - All arithmetic is mod 2^32.
- MUL → IDLE on the edge where `cnt == 31`. On that edge the final `acc`, including that edge's addition, is written to `result`, and `out_valid` is set to 1.

Handshake:
- `in_ready = (state == IDLE) && (!out_valid || out_ready)`.
- An operation is accepted when `in_valid && in_ready`.
- The result is consumed when `out_valid && out_ready`. `out_valid` then clears unless a new single-cycle result loads on the same edge.
- `result` and `out_valid` hold steady while `out_valid && !out_ready`.

Flush:
- `flush` has the highest priority after reset. On the edge: state → IDLE, `out_valid` → 0, `cnt` → 0.
- An operation presented in the same cycle is discarded.
- `result` keeps its old value.

## Timing
- Reset values:
  - state IDLE
  - `out_valid` 0
  - `result` 0, so `zero` is 1
  - `cnt`, `acc`, `mcand`, `mplier` all 0
  - `in_ready` reads 1 once reset is released.
- Reset asserted mid-multiply aborts the operation immediately and produces no output.
- Single-cycle ops: accepted at edge k, `out_valid` = 1 and `result` valid after edge k.
- Back-to-back single-cycle ops with `out_ready` held at 1 give one result per cycle.
- Multiply: accepted at edge k. MUL edges are k+1 … k+32. `out_valid` rises after edge k+32. `in_ready` = 0 for the 32 cycles in between.
- A multiply can be accepted while an older result is being consumed (`out_ready` = 1 that cycle).
- Shifts with `shamt` = 0 return `b` unchanged.
- `zero` follows `result` combinationally with no extra latency.

## Test plan
- Reset, then drive code 2 with a = 0x7FFFFFFF, b = 1 and `out_ready` = 1 → one cycle later `result` = 0x80000000 and `zero` = 0. Then code 6 with a = b = 5 → `result` = 0 and `zero` = 1.
- Code 7 with a = 0xFFFFFFFF, b = 1 → 1. Code 13 with b = 1, shamt = 31 → 0x80000000. Code 14 with b = 0x80000000, shamt = 31 → 1. Code 3 → 0.
- Code 15 with a = 0x00010003, b = 0x00020005 → `in_ready` low for exactly 32 cycles, then `result` = 0x000B000F. Repeat with a = 0xFFFFFFFD, b = 7 → 0xFFFFFFEB.
- Hold `out_ready` = 0 after a code-0 result, keep `in_valid` = 1 → `in_ready` = 0 and `result` stable. Raise `out_ready` → the next op is accepted on the same edge, with no lost or duplicated result.
- Start a multiply, assert `flush` at MUL cycle 10 → `out_valid` stays 0 and `in_ready` = 1 the next cycle. A following code-1 op completes normally.
- Start a multiply, pulse `resetn` low mid-operation → all outputs return to reset values immediately, and no result appears after release.
